// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit.
// Holds the access FSM state encoding, the default data/address widths
// and the fill value a load returns when the optional watchdog aborts it.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int MEM_DATA_W = 8;
  localparam int MEM_ADDR_W = 8;

  localparam logic [7:0] MEM_ABORT_DATA = 8'hFF;

endpackage

// File: rtl/memory_access_unit_timeout_counter.sv
// Watchdog cycle counter for the memory access unit.
// Only compiled when MEM_TIMEOUT_EN is defined; otherwise the unit has no
// watchdog and this module does not exist in the build.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT) + 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Expiry is flagged during the LIMIT-th enabled cycle so the caller can
  // leave on the following edge.
  assign expired = enable && (count_q == CNT_W'(LIMIT - 1));

  // Next count: held at zero while cleared, advances while enabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/memory_access_unit.sv
// Sequential load/store engine between the CPU memory stage and data memory.
// Runs one request/grant/response access at a time, stalls the pipeline
// while it is outstanding and holds the last loaded byte on memData.
// Optional watchdog abort is enabled by defining MEM_TIMEOUT_EN.
module memory_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W         = MEM_DATA_W,
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] storeData,
  output logic              stall,
  output logic [DATA_W-1:0] memData,
  output logic              memDataValid,
  output logic              memError,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic              memGnt,
  input  logic              memRvalid,
  input  logic [DATA_W-1:0] memRdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("memory_access_unit: TIMEOUT_CYCLES must be at least 1");
  end

  mem_state_t        state_q, state_d;
  logic              is_load_q, is_load_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              timeout_hit;

`ifdef MEM_TIMEOUT_EN
  logic aborted_q, aborted_d;
  logic cnt_clear;
  logic cnt_enable;

  // The counter sits at zero in IDLE, so it starts from zero on entry to REQ.
  assign cnt_clear  = (state_q == IDLE);
  assign cnt_enable = (state_q == REQ) || (state_q == WAIT);

  mem_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(timeout_hit)
  );

  assign memError = (state_q == DONE) && aborted_q;
`else
  assign timeout_hit = 1'b0;
  assign memError    = 1'b0;
`endif

  // Access FSM: capture the op in IDLE, handshake in REQ/WAIT, commit in DONE.
  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_data_d = mem_data_q;
`ifdef MEM_TIMEOUT_EN
    aborted_d  = aborted_q;
`endif
    case (state_q)
      IDLE: begin
        if (memRead || memWrite) begin
          is_load_d = memRead;
          addr_d    = address;
          wdata_d   = storeData;
          state_d   = REQ;
`ifdef MEM_TIMEOUT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      REQ: begin
        if (memGnt) begin
          if (!is_load_q) begin
            state_d = DONE;
          end else if (memRvalid) begin
            mem_data_d = memRdata;
            state_d    = DONE;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout_hit) begin
          state_d = DONE;
          if (is_load_q) begin
            mem_data_d = DATA_W'(MEM_ABORT_DATA);
          end
`ifdef MEM_TIMEOUT_EN
          aborted_d = 1'b1;
`endif
        end
      end
      WAIT: begin
        if (memRvalid) begin
          mem_data_d = memRdata;
          state_d    = DONE;
        end else if (timeout_hit) begin
          state_d    = DONE;
          mem_data_d = DATA_W'(MEM_ABORT_DATA);
`ifdef MEM_TIMEOUT_EN
          aborted_d  = 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-operand registers; reset abandons any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      is_load_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_data_q <= '0;
`ifdef MEM_TIMEOUT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_data_q <= mem_data_d;
`ifdef MEM_TIMEOUT_EN
      aborted_q  <= aborted_d;
`endif
    end
  end

  assign stall        = (state_q == REQ) || (state_q == WAIT) ||
                        ((state_q == IDLE) && (memRead || memWrite));
  assign memReq       = (state_q == REQ);
  assign memWe        = (state_q == REQ) && !is_load_q;
  assign memAddr      = addr_q;
  assign memWdata     = wdata_q;
  assign memData      = mem_data_q;
  assign memDataValid = (state_q == DONE) && is_load_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit.
// Covers load/store handshakes, read/write collision, asynchronous reset
// mid-access and, when MEM_TIMEOUT_EN is defined, the watchdog abort.
module tb_memory_access_unit;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              memRead = 1'b0;
  logic              memWrite = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] storeData = '0;
  logic              stall;
  logic [DATA_W-1:0] memData;
  logic              memDataValid;
  logic              memError;
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              memGnt = 1'b0;
  logic              memRvalid = 1'b0;
  logic [DATA_W-1:0] memRdata = '0;

  int compared = 0;
  int mismatched = 0;

  memory_access_unit #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .address     (address),
    .storeData   (storeData),
    .stall       (stall),
    .memData     (memData),
    .memDataValid(memDataValid),
    .memError    (memError),
    .memReq      (memReq),
    .memWe       (memWe),
    .memAddr     (memAddr),
    .memWdata    (memWdata),
    .memGnt      (memGnt),
    .memRvalid   (memRvalid),
    .memRdata    (memRdata)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [7:0] addr, input logic [7:0] wdata,
                               input logic gnt, input logic rv,
                               input logic [7:0] rdata);
    @(negedge clk);
    memRead   = rd;
    memWrite  = wr;
    address   = addr;
    storeData = wdata;
    memGnt    = gnt;
    memRvalid = rv;
    memRdata  = rdata;
    #1;
  endtask

  // Linear directed sequence.
  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_req", memReq, 0);
    checkOutput("rst_we", memWe, 0);
    checkOutput("rst_data", memData, 8'h00);
    checkOutput("rst_valid", memDataValid, 0);
    checkOutput("rst_err", memError, 0);
    @(negedge clk);
    reset = 1'b0;

    // Load 0x3C, grant in REQ, response one cycle later
    applyStimulus(1, 0, 8'h3C, 8'h00, 0, 0, 8'h00);
    checkOutput("ld1_issue_stall", stall, 1);
    checkOutput("ld1_issue_req", memReq, 0);
    applyStimulus(1, 0, 8'h3C, 8'h00, 1, 0, 8'h00);
    checkOutput("ld1_req_stall", stall, 1);
    checkOutput("ld1_req_req", memReq, 1);
    checkOutput("ld1_req_we", memWe, 0);
    checkOutput("ld1_req_addr", memAddr, 8'h3C);
    applyStimulus(1, 0, 8'h3C, 8'h00, 0, 1, 8'hA5);
    checkOutput("ld1_wait_stall", stall, 1);
    checkOutput("ld1_wait_req", memReq, 0);
    checkOutput("ld1_wait_valid", memDataValid, 0);
    applyStimulus(1, 0, 8'h3C, 8'h00, 0, 0, 8'h00);
    checkOutput("ld1_done_stall", stall, 0);
    checkOutput("ld1_done_valid", memDataValid, 1);
    checkOutput("ld1_done_data", memData, 8'hA5);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    checkOutput("ld1_after_valid", memDataValid, 0);
    checkOutput("ld1_after_stall", stall, 0);
    checkOutput("ld1_after_data", memData, 8'hA5);

    // Store 0x5A to 0x10, grant delayed two cycles; payload must hold
    applyStimulus(0, 1, 8'h10, 8'h5A, 0, 0, 8'h00);
    checkOutput("st_issue_stall", stall, 1);
    applyStimulus(0, 1, 8'hEE, 8'h00, 0, 0, 8'h00);
    checkOutput("st_req1_req", memReq, 1);
    checkOutput("st_req1_we", memWe, 1);
    checkOutput("st_req1_addr", memAddr, 8'h10);
    checkOutput("st_req1_wdata", memWdata, 8'h5A);
    applyStimulus(0, 1, 8'hEE, 8'h00, 0, 0, 8'h00);
    checkOutput("st_req2_req", memReq, 1);
    checkOutput("st_req2_stall", stall, 1);
    checkOutput("st_req2_addr", memAddr, 8'h10);
    applyStimulus(0, 1, 8'hEE, 8'h00, 1, 0, 8'h00);
    checkOutput("st_gnt_req", memReq, 1);
    checkOutput("st_gnt_we", memWe, 1);
    checkOutput("st_gnt_wdata", memWdata, 8'h5A);
    applyStimulus(0, 1, 8'hEE, 8'h00, 0, 0, 8'h00);
    checkOutput("st_done_stall", stall, 0);
    checkOutput("st_done_req", memReq, 0);
    checkOutput("st_done_valid", memDataValid, 0);
    checkOutput("st_done_data", memData, 8'hA5);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    checkOutput("st_after_req", memReq, 0);

    // Load with grant and response in the same cycle
    applyStimulus(1, 0, 8'h20, 8'h00, 0, 0, 8'h00);
    checkOutput("ld2_issue_stall", stall, 1);
    applyStimulus(1, 0, 8'h20, 8'h00, 1, 1, 8'h77);
    checkOutput("ld2_req_req", memReq, 1);
    checkOutput("ld2_req_addr", memAddr, 8'h20);
    applyStimulus(1, 0, 8'h20, 8'h00, 0, 0, 8'h00);
    checkOutput("ld2_done_stall", stall, 0);
    checkOutput("ld2_done_valid", memDataValid, 1);
    checkOutput("ld2_done_data", memData, 8'h77);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    checkOutput("ld2_after_req", memReq, 0);

    // Read and write both high: treated as a load
    applyStimulus(1, 1, 8'h44, 8'h99, 0, 0, 8'h00);
    checkOutput("rw_issue_stall", stall, 1);
    applyStimulus(1, 1, 8'h44, 8'h99, 1, 1, 8'h12);
    checkOutput("rw_req_req", memReq, 1);
    checkOutput("rw_req_we", memWe, 0);
    checkOutput("rw_req_addr", memAddr, 8'h44);
    applyStimulus(1, 1, 8'h44, 8'h99, 0, 0, 8'h00);
    checkOutput("rw_done_valid", memDataValid, 1);
    checkOutput("rw_done_data", memData, 8'h12);
    checkOutput("rw_done_we", memWe, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00);

    // Reset asserted while waiting for the response
    applyStimulus(1, 0, 8'h08, 8'h00, 0, 0, 8'h00);
    applyStimulus(1, 0, 8'h08, 8'h00, 1, 0, 8'h00);
    applyStimulus(1, 0, 8'h08, 8'h00, 0, 0, 8'h00);
    checkOutput("rstw_wait_stall", stall, 1);
    checkOutput("rstw_wait_req", memReq, 0);
    #1;
    reset   = 1'b1;
    memRead = 1'b0;
    #1;
    checkOutput("rstw_stall", stall, 0);
    checkOutput("rstw_req", memReq, 0);
    checkOutput("rstw_data", memData, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 8'hCC);
    checkOutput("rstw_late_stall", stall, 0);
    checkOutput("rstw_late_valid", memDataValid, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    checkOutput("rstw_late_data", memData, 8'h00);
    checkOutput("rstw_late_valid2", memDataValid, 0);
    checkOutput("rstw_late_err", memError, 0);

`ifdef MEM_TIMEOUT_EN
    // Load granted but never answered: abort after four counted cycles
    applyStimulus(1, 0, 8'h50, 8'h00, 0, 0, 8'h00);
    applyStimulus(1, 0, 8'h50, 8'h00, 1, 0, 8'h00);
    checkOutput("to_req_req", memReq, 1);
    applyStimulus(1, 0, 8'h50, 8'h00, 0, 0, 8'h00);
    checkOutput("to_wait1_stall", stall, 1);
    applyStimulus(1, 0, 8'h50, 8'h00, 0, 0, 8'h00);
    checkOutput("to_wait2_stall", stall, 1);
    applyStimulus(1, 0, 8'h50, 8'h00, 0, 0, 8'h00);
    checkOutput("to_wait3_stall", stall, 1);
    checkOutput("to_wait3_err", memError, 0);
    applyStimulus(1, 0, 8'h50, 8'h00, 0, 0, 8'h00);
    checkOutput("to_done_stall", stall, 0);
    checkOutput("to_done_err", memError, 1);
    checkOutput("to_done_data", memData, 8'hFF);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 8'h33);
    checkOutput("to_late_err", memError, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    checkOutput("to_late_data", memData, 8'hFF);
    checkOutput("to_late_valid", memDataValid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
